booth_mult_seq: RTL and testbench

BOOTH_MULT_SEQ -- requirements
Module: booth_mult_seq

---
 rtl/booth_pkg.sv | 27 ++
 rtl/booth_mult_seq_if.sv | 27 ++
 rtl/booth_digit_enc.sv | 19 +
 rtl/booth_mult_seq.sv | 111 +++++++++++
 tb/tb_booth_mult_seq.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/booth_pkg.sv
// Shared types and helpers for the sequential radix-4 Booth multiplier.
//   state_t    : controller states (IDLE, BUSY, DONE)
//   digit_t    : decoded radix-4 Booth digit (magnitude selects plus sign)
//   num_digits : how many radix-4 digits an operation takes for a given
//                operand width and signedness
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic single;
        logic double;
        logic neg;
    } digit_t;

    // Unsigned operands are zero-extended by two bits, which adds one digit
    // so that the top (sign) digit of the recoded multiplier is never negative.
    function automatic int unsigned num_digits(input int unsigned width,
                                               input logic        is_signed);
        return is_signed ? (width / 2) : (width / 2 + 1);
    endfunction

endpackage

// File: rtl/booth_mult_seq_if.sv
// Operand/result handshake bundle for booth_mult_seq.
//   in_valid/in_ready   : operand handshake (a, b, is_signed)
//   out_valid/out_ready : result handshake (product)
//   master modport : operand producer and result consumer
//   slave modport  : the multiplier
interface booth_mult_seq_if #(parameter int WIDTH = 8);

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 is_signed;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output in_valid, a, b, is_signed, out_ready,
        input  in_ready, out_valid, product
    );

    modport slave (
        input  in_valid, a, b, is_signed, out_ready,
        output in_ready, out_valid, product
    );

endinterface

// File: rtl/booth_digit_enc.sv
// Radix-4 Booth digit decoder (purely combinational).
//   win_i   : multiplier window {bit 2k+1, bit 2k, bit 2k-1}
//   digit_o : single (|d|=1), double (|d|=2), neg (sign of d)
// Code 111 decodes to neg with zero magnitude, which the datapath treats
// as subtracting zero, so it contributes nothing.
module booth_digit_enc
    import booth_pkg::*;
(
    input  logic [2:0] win_i,
    output digit_t     digit_o
);

    always_comb begin
        digit_o.single = win_i[0] ^ win_i[1];
        digit_o.double = (win_i[2] ^ win_i[0]) & ~(win_i[0] ^ win_i[1]);
        digit_o.neg    = win_i[2];
    end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-4 Booth multiplier, one digit per clock.
//   clk   : rising-edge clock
//   reset : synchronous, active-high; aborts any operation in flight
//   bus   : booth_mult_seq_if.slave
//             in_valid/in_ready/a/b/is_signed : operand acceptance (IDLE only)
//             out_valid/out_ready/product     : result, held until taken
// Latency: out_valid rises D edges after the accepting edge, where
// D = WIDTH/2 (signed) or WIDTH/2+1 (unsigned).
module booth_mult_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
)
(
    input  logic              clk,
    input  logic              reset,
    booth_mult_seq_if.slave   bus
);

    localparam int ACC_W = 2 * WIDTH + 2;
    localparam int MUL_W = WIDTH + 3;          // 2 extension bits + implicit bit -1
    localparam int CNT_W = $clog2(WIDTH / 2 + 2);

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   mcand_q, mcand_d;      // multiplicand, pre-shifted by 2k
    logic [MUL_W-1:0]   mult_q, mult_d;        // multiplier, window sits in [2:0]
    logic               signed_q, signed_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   last_digit;
    logic [ACC_W-1:0]   pp;
    digit_t             digit;

    booth_digit_enc u_enc (
        .win_i   (mult_q[2:0]),
        .digit_o (digit)
    );

    assign bus.in_ready  = (state_q == IDLE) && !reset;
    assign bus.out_valid = (state_q == DONE);
    assign bus.product   = acc_q[2*WIDTH-1:0];

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mult_d     = mult_q;
        signed_d   = signed_q;
        cnt_d      = cnt_q;
        last_digit = CNT_W'(num_digits(WIDTH, signed_q) - 1);

        // Magnitude of the current digit times the multiplicand; the sign is
        // applied by choosing add or subtract below.
        if (digit.single) begin
            pp = mcand_q;
        end else if (digit.double) begin
            pp = {mcand_q[ACC_W-2:0], 1'b0};
        end else begin
            pp = '0;
        end

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    mcand_d  = {{(ACC_W-WIDTH){bus.is_signed & bus.a[WIDTH-1]}}, bus.a};
                    mult_d   = {{2{bus.is_signed & bus.b[WIDTH-1]}}, bus.b, 1'b0};
                    signed_d = bus.is_signed;
                    cnt_d    = '0;
                    acc_d    = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                acc_d   = digit.neg ? (acc_q - pp) : (acc_q + pp);
                mcand_d = {mcand_q[ACC_W-3:0], 2'b00};
                mult_d  = {2'b00, mult_q[MUL_W-1:2]};
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == last_digit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mult_q   <= '0;
            signed_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mult_q   <= mult_d;
            signed_q <= signed_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_booth_mult_seq.sv
module tb_booth_mult_seq;

    localparam int W = 8;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    booth_mult_seq_if #(.WIDTH(W)) bus ();

    booth_mult_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer multiplication, truncated to the product width.
    function automatic logic [2*W-1:0] ref_mult(input logic [W-1:0] a,
                                                input logic [W-1:0] b,
                                                input logic s);
        int x;
        int y;
        if (s) begin
            x = int'($signed(a));
            y = int'($signed(b));
        end else begin
            x = int'(a);
            y = int'(b);
        end
        return (2*W)'(x * y);
    endfunction

    function automatic int ref_lat(input logic s);
        return s ? (W / 2) : (W / 2 + 1);
    endfunction

    // Present operands at a negedge, wait for acceptance, then count rising
    // edges until out_valid is seen. Returns at a negedge in DONE with the
    // result not yet taken. lat = -1 if anything timed out.
    task automatic start_and_wait(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic s, input int gap_in,
                                  input bit scramble,
                                  output int lat, output bit ready_in_busy);
        int guard;
        int n;
        bit found;
        ready_in_busy = 1'b0;
        repeat (gap_in) @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.a         = a;
        bus.b         = b;
        bus.is_signed = s;
        guard = 0;
        while (!bus.in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.in_ready) begin
            bus.in_valid = 1'b0;
            lat = -1;
            return;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        if (scramble) begin
            bus.a         = W'($urandom);
            bus.b         = W'($urandom);
            bus.is_signed = 1'($urandom);
        end
        n = 0;
        found = 1'b0;
        while (!found && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (bus.out_valid) found = 1'b1;
            else if (bus.in_ready) ready_in_busy = 1'b1;
        end
        lat = found ? n : -1;
    endtask

    task automatic pop_result(input int gap_out);
        repeat (gap_out) @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.is_signed = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (bus.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_in_ready_high: got %b want 0", bus.in_ready);
        end
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
        end
        vectors++;
        if (bus.product !== '0) begin
            miscompares++;
            $display("FAIL reset_product: got %h want 0000", bus.product);
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_in_ready: got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0]   ta [4] = '{8'h80, 8'h7F, 8'h05, 8'hFF};
        logic [W-1:0]   tb [4] = '{8'h80, 8'h80, 8'hFF, 8'hFF};
        logic           ts [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [2*W-1:0] tp [4] = '{16'h4000, 16'hC080, 16'hFFFB, 16'hFE01};
        int             tl [4] = '{4, 4, 4, 5};
        int lat;
        bit rb;
        for (int i = 0; i < 4; i++) begin
            start_and_wait(ta[i], tb[i], ts[i], 0, 1'b1, lat, rb);
            vectors++;
            if (bus.product !== tp[i]) begin
                miscompares++;
                $display("FAIL directed_product[%0d]: got %h want %h", i, bus.product, tp[i]);
            end
            vectors++;
            if (lat != tl[i]) begin
                miscompares++;
                $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, tl[i]);
            end
            vectors++;
            if (rb) begin
                miscompares++;
                $display("FAIL directed_in_ready_busy[%0d]: got 1 want 0", i);
            end
            pop_result(0);
        end
    endtask

    task automatic test_hold();
        int lat;
        bit rb;
        bit bad;
        logic [2*W-1:0] exp;
        exp = ref_mult(8'hA5, 8'h3C, 1'b1);
        start_and_wait(8'hA5, 8'h3C, 1'b1, 0, 1'b0, lat, rb);
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.product !== exp || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0)
                bad = 1'b1;
        end
        vectors++;
        if (bad || lat < 0) begin
            miscompares++;
            $display("FAIL hold_stable: product %h out_valid %b in_ready %b want %h 1 0",
                     bus.product, bus.out_valid, bus.in_ready, exp);
        end
        pop_result(0);
    endtask

    task automatic test_abort();
        int lat;
        bit rb;
        bit seen;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.a         = 8'h7B;
        bus.b         = 8'h91;
        bus.is_signed = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        vectors++;
        if (bus.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_in_ready_in_reset: got %b want 0", bus.in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        vectors++;
        if (bus.in_ready !== 1'b1 || bus.product !== '0) begin
            miscompares++;
            $display("FAIL abort_after_reset: in_ready %b product %h want 1 0000",
                     bus.in_ready, bus.product);
        end
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        vectors++;
        if (seen) begin
            miscompares++;
            $display("FAIL abort_no_out_valid: got out_valid want none");
        end
        start_and_wait(8'h03, 8'h03, 1'b1, 0, 1'b1, lat, rb);
        vectors++;
        if (bus.product !== 16'h0009 || lat != 4) begin
            miscompares++;
            $display("FAIL abort_followup: product %h lat %0d want 0009 4", bus.product, lat);
        end
        pop_result(0);
    endtask

    task automatic test_back_to_back();
        int lat;
        bit rb;
        int n;
        bit found;
        logic [2*W-1:0] exp;
        start_and_wait(8'h12, 8'h34, 1'b0, 0, 1'b0, lat, rb);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.a         = 8'hC3;
        bus.b         = 8'h5E;
        bus.is_signed = 1'b1;
        exp = ref_mult(8'hC3, 8'h5E, 1'b1);
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_no_accept_in_done: out_valid %b in_ready %b want 0 1",
                     bus.out_valid, bus.in_ready);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        n = 0;
        found = 1'b0;
        while (!found && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (bus.out_valid) found = 1'b1;
        end
        vectors++;
        if (!found || n != ref_lat(1'b1) || bus.product !== exp) begin
            miscompares++;
            $display("FAIL b2b_second_op: product %h lat %0d want %h %0d",
                     bus.product, n, exp, ref_lat(1'b1));
        end
        pop_result(0);
    endtask

    task automatic test_random();
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic s;
        logic [2*W-1:0] exp;
        int lat;
        bit rb;
        for (int i = 0; i < 1000; i++) begin
            a   = W'($urandom);
            b   = W'($urandom);
            s   = 1'($urandom);
            exp = ref_mult(a, b, s);
            start_and_wait(a, b, s, $urandom_range(0, 3), 1'b1, lat, rb);
            vectors++;
            if (bus.product !== exp) begin
                miscompares++;
                $display("FAIL rand_product[%0d] %h*%h s=%b: got %h want %h",
                         i, a, b, s, bus.product, exp);
            end
            vectors++;
            if (lat != ref_lat(s)) begin
                miscompares++;
                $display("FAIL rand_latency[%0d]: got %0d want %0d", i, lat, ref_lat(s));
            end
            vectors++;
            if (rb) begin
                miscompares++;
                $display("FAIL rand_in_ready_busy[%0d]: got 1 want 0", i);
            end
            pop_result($urandom_range(0, 3));
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_directed();
        test_hold();
        test_abort();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
